// File: rtl/bcd_to_unsigned.sv
// Sequential packed-BCD to binary converter using reverse double-dabble,
// one bit per clock, with a trigger/idle handshake and illegal-digit flag.
module bcd_to_unsigned #(
    parameter int N_DIGITS = 8,
    parameter int OUT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic [4*N_DIGITS-1:0] bcd,
    output logic                  idle,
    output logic                  done,
    output logic [OUT_W-1:0]      out,
    output logic                  error
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = (BCD_W > 1) ? $clog2(BCD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BCD_W - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_FINISH  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [BCD_W-1:0] d_q, d_d;
    logic [BCD_W-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             error_q, error_d;

    logic             bcd_bad;
    logic [BCD_W-1:0] d_shift, d_corr, b_shift;

    // NOTE: every variable assigned in an always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
        end
    end

    // One reverse double-dabble step: shift {D,B} right, then pull every
    // D digit that landed at 8 or above back by 3.
    always_comb begin
        d_shift = {1'b0, d_q[BCD_W-1:1]};
        b_shift = {d_q[0], b_q[BCD_W-1:1]};
        d_corr  = d_shift;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (d_shift[4*i +: 4] >= 4'd8) d_corr[4*i +: 4] = d_shift[4*i +: 4] - 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        out_d   = out_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    d_d     = bcd;
                    b_d     = '0;
                    cnt_d   = '0;
                    err_d   = bcd_bad;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                d_d   = d_corr;
                b_d   = b_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) state_d = S_FINISH;
            end
            S_FINISH: begin
                out_d   = err_q ? '0 : OUT_W'(b_q);
                error_d = err_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            out_q   <= out_d;
            error_q <= error_d;
        end
    end

    assign idle  = (state_q == S_IDLE);
    assign done  = done_q;
    assign out   = out_q;
    assign error = error_q;

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Self-checking bench for bcd_to_unsigned: directed cases plus randomized
// BCD words compared against a decimal-arithmetic reference model.
module tb_bcd_to_unsigned;

    logic        clk;
    logic        rst;
    logic        trigger;
    logic [31:0] bcd;
    logic        idle;
    logic        done;
    logic [31:0] out;
    logic        error;

    int checks = 0;
    int errors = 0;

    bcd_to_unsigned #(.N_DIGITS(8), .OUT_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger),
        .bcd     (bcd),
        .idle    (idle),
        .done    (done),
        .out     (out),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal value of the digit string; any digit above 9 yields 0 plus error.
    function automatic void model(input logic [31:0] v, output longint val, output bit bad);
        longint dig;
        val = 0;
        bad = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            dig = longint'(v[4*i +: 4]);
            if (dig > 9) bad = 1'b1;
            val = val * 10 + dig;
        end
        if (bad) val = 0;
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    task automatic run_conv(input logic [31:0] v, input string tag);
        int     n;
        longint ev;
        bit     eb;
        model(v, ev, eb);
        @(negedge clk);
        check({tag, ".idle_pre"}, 64'(idle), 64'd1);
        bcd     = v;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        bcd     = $urandom;
        check({tag, ".busy"}, 64'(idle), 64'd0);
        wait_done(n);
        check({tag, ".latency"}, 64'(n), 64'd33);
        check({tag, ".out"}, 64'(out), 64'(ev));
        check({tag, ".error"}, 64'(error), 64'(eb));
        check({tag, ".idle_done"}, 64'(idle), 64'd1);
        @(negedge clk);
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
        check({tag, ".out_hold"}, 64'(out), 64'(ev));
    endtask

    initial begin
        int          n;
        int          nd;
        longint      ev;
        bit          eb;
        logic [31:0] v;

        rst     = 1'b1;
        trigger = 1'b0;
        bcd     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset.idle", 64'(idle), 64'd1);
        check("reset.done", 64'(done), 64'd0);
        check("reset.out", 64'(out), 64'd0);
        check("reset.error", 64'(error), 64'd0);

        run_conv(32'h0012_3456, "basic");
        run_conv(32'h9999_9999, "max");
        run_conv(32'h0000_0000, "zero");
        run_conv(32'h0012_A456, "illegal");
        run_conv(32'h0000_0059, "after_illegal");
        run_conv(32'hF000_0000, "illegal_msd");

        // Trigger pulsed mid-conversion must be ignored.
        @(negedge clk);
        bcd     = 32'h0013_0000;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (9) @(negedge clk);
        bcd     = 32'h0000_0001;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_done(n);
        check("busy.latency", 64'(n), 64'd23);
        check("busy.out", 64'(out), 64'd130000);
        count_dones(60, nd);
        check("busy.no_second_done", 64'(nd), 64'd0);

        // Trigger tied high: done every 34 cycles.
        @(negedge clk);
        bcd     = 32'h0023_5959;
        trigger = 1'b1;
        wait_done(n);
        check("b2b.first_latency", 64'(n), 64'd34);
        check("b2b.first_out", 64'(out), 64'd235959);
        bcd = 32'h0000_0000;
        wait_done(n);
        trigger = 1'b0;
        check("b2b.period", 64'(n), 64'd34);
        check("b2b.second_out", 64'(out), 64'd0);
        count_dones(50, nd);
        check("b2b.stopped", 64'(nd), 64'd0);

        // Reset mid-flight aborts and clears the held result.
        run_conv(32'h0000_0007, "pre_reset");
        @(negedge clk);
        bcd     = 32'h0012_0000;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.idle", 64'(idle), 64'd1);
        check("midrst.out", 64'(out), 64'd0);
        check("midrst.error", 64'(error), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        count_dones(40, nd);
        check("midrst.no_done", 64'(nd), 64'd0);
        run_conv(32'h0000_0042, "post_reset");

        // Random words, roughly a quarter with one illegal digit.
        for (int t = 0; t < 24; t++) begin
            v = '0;
            for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) v[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
            model(v, ev, eb);
            run_conv(v, $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
